// File: rtl/cap_xfer_seq.sv
// Capability load/store sequencer between the MEM stage and the dcache port.
// Checks the authorising capability, then moves a capability as twelve
// 24-bit words (base/len/cur lo-hi pairs, then perms, attr, tag, each with a
// zero pad word). Loads are delivered to the CR write port in one cycle.
//
// state   | meaning
// S_IDLE  | waiting for start; request fields latched on start
// S_CHECK | one-cycle tag/permission/bounds check of the latched request
// S_XFER  | word k on the dcache port; advances on req & ack
// S_FIN   | one-cycle done pulse with fault code or CR write
module cap_xfer_seq #(
  parameter int ADDR_W      = 48,
  parameter int WORD_W      = 24,
  parameter int PERM_LC_BIT = 0,
  parameter int PERM_SC_BIT = 1
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              iw_start,
  input  logic              iw_store,
  input  logic [ADDR_W-1:0] iw_addr,
  input  logic [ADDR_W-1:0] iw_auth_base,
  input  logic [ADDR_W-1:0] iw_auth_len,
  input  logic [WORD_W-1:0] iw_auth_perms,
  input  logic              iw_auth_tag,
  input  logic [ADDR_W-1:0] iw_st_base,
  input  logic [ADDR_W-1:0] iw_st_len,
  input  logic [ADDR_W-1:0] iw_st_cur,
  input  logic [WORD_W-1:0] iw_st_perms,
  input  logic [WORD_W-1:0] iw_st_attr,
  input  logic              iw_st_tag,
  input  logic              iw_flush,
  output logic              ow_busy,
  output logic              ow_done,
  output logic              ow_fault,
  output logic [1:0]        ow_fault_code,
  output logic              ow_mem_req,
  output logic              ow_mem_we,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [WORD_W-1:0] ow_mem_wdata,
  input  logic              iw_mem_ack,
  input  logic [WORD_W-1:0] iw_mem_rdata,
  output logic              ow_cr_we,
  output logic [ADDR_W-1:0] ow_cr_base,
  output logic [ADDR_W-1:0] ow_cr_len,
  output logic [ADDR_W-1:0] ow_cr_cur,
  output logic [WORD_W-1:0] ow_cr_perms,
  output logic [WORD_W-1:0] ow_cr_attr,
  output logic              ow_cr_tag
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_XFER, S_FIN} state_t;

  state_t            r_state;
  logic [3:0]        r_k;
  logic              r_store;
  logic [ADDR_W-1:0] r_addr, r_a_base, r_a_len;
  logic [WORD_W-1:0] r_a_perms;
  logic              r_a_tag;
  logic [ADDR_W-1:0] r_s_base, r_s_len, r_s_cur;
  logic [WORD_W-1:0] r_s_perms, r_s_attr;
  logic              r_s_tag;
  logic [ADDR_W-1:0] r_c_base, r_c_len, r_c_cur;
  logic [WORD_W-1:0] r_c_perms, r_c_attr;
  logic              r_c_tag;
  logic              r_busy, r_done, r_fault, r_mem_req, r_mem_we, r_cr_we;
  logic [1:0]        r_code;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;

  logic [ADDR_W:0]   w_end_req, w_end_lim;
  logic              w_perm_ok;
  logic [1:0]        w_code;
  logic [3:0]        w_k_next;

  // Store word order in memory; pad words are zero.
  function automatic logic [WORD_W-1:0] f_word(input logic [3:0] k,
      input logic [ADDR_W-1:0] b, l, c, input logic [WORD_W-1:0] p, a,
      input logic t);
    logic [WORD_W-1:0] w;
    case (k)
      4'd0:    w = b[WORD_W-1:0];
      4'd1:    w = b[ADDR_W-1:WORD_W];
      4'd2:    w = l[WORD_W-1:0];
      4'd3:    w = l[ADDR_W-1:WORD_W];
      4'd4:    w = c[WORD_W-1:0];
      4'd5:    w = c[ADDR_W-1:WORD_W];
      4'd6:    w = p;
      4'd8:    w = a;
      4'd10:   w = {{(WORD_W-1){1'b0}}, t};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign w_k_next  = r_k + 4'd1;
  assign w_end_req = {1'b0, r_addr} + (ADDR_W+1)'(12);
  assign w_end_lim = {1'b0, r_a_base} + {1'b0, r_a_len};
  assign w_perm_ok = r_store ? r_a_perms[PERM_SC_BIT] : r_a_perms[PERM_LC_BIT];

  // Fault classification of the latched request, highest priority first.
  always_comb begin
    w_code = 2'd0;
    if (!r_a_tag)
      w_code = 2'd1;
    else if (!w_perm_ok)
      w_code = 2'd2;
    else if ((r_addr < r_a_base) || (w_end_req > w_end_lim))
      w_code = 2'd3;
  end

  // Sequencer state, registered outputs and load assembly register.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      r_state <= S_IDLE;  r_k <= '0;  r_store <= 1'b0;
      r_addr <= '0;  r_a_base <= '0;  r_a_len <= '0;  r_a_perms <= '0;  r_a_tag <= 1'b0;
      r_s_base <= '0;  r_s_len <= '0;  r_s_cur <= '0;
      r_s_perms <= '0;  r_s_attr <= '0;  r_s_tag <= 1'b0;
      r_c_base <= '0;  r_c_len <= '0;  r_c_cur <= '0;
      r_c_perms <= '0;  r_c_attr <= '0;  r_c_tag <= 1'b0;
      r_busy <= 1'b0;  r_done <= 1'b0;  r_fault <= 1'b0;  r_code <= 2'd0;
      r_mem_req <= 1'b0;  r_mem_we <= 1'b0;  r_mem_addr <= '0;  r_mem_wdata <= '0;
      r_cr_we <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iw_start) begin
            r_store <= iw_store;  r_addr <= iw_addr;
            r_a_base <= iw_auth_base;  r_a_len <= iw_auth_len;
            r_a_perms <= iw_auth_perms;  r_a_tag <= iw_auth_tag;
            r_s_base <= iw_st_base;  r_s_len <= iw_st_len;  r_s_cur <= iw_st_cur;
            r_s_perms <= iw_st_perms;  r_s_attr <= iw_st_attr;  r_s_tag <= iw_st_tag;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (iw_flush) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_code != 2'd0) begin
            r_done  <= 1'b1;
            r_fault <= 1'b1;
            r_code  <= w_code;
            r_state <= S_FIN;
          end else begin
            r_k         <= '0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= r_store;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_store ? f_word(4'd0, r_s_base, r_s_len, r_s_cur,
                                            r_s_perms, r_s_attr, r_s_tag) : '0;
            r_state     <= S_XFER;
          end
        end
        S_XFER: begin
          if (iw_mem_ack) begin
            if (!r_store) begin
              case (r_k)
                4'd0:    r_c_base[WORD_W-1:0]      <= iw_mem_rdata;
                4'd1:    r_c_base[ADDR_W-1:WORD_W] <= iw_mem_rdata;
                4'd2:    r_c_len[WORD_W-1:0]       <= iw_mem_rdata;
                4'd3:    r_c_len[ADDR_W-1:WORD_W]  <= iw_mem_rdata;
                4'd4:    r_c_cur[WORD_W-1:0]       <= iw_mem_rdata;
                4'd5:    r_c_cur[ADDR_W-1:WORD_W]  <= iw_mem_rdata;
                4'd6:    r_c_perms                 <= iw_mem_rdata;
                4'd8:    r_c_attr                  <= iw_mem_rdata;
                4'd10:   r_c_tag                   <= iw_mem_rdata[0];
                default: ;
              endcase
            end
            if (iw_flush || (r_k == 4'd11)) begin
              r_k         <= '0;
              r_mem_req   <= 1'b0;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= '0;
              r_mem_wdata <= '0;
              if (iw_flush) begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_done  <= 1'b1;
                r_cr_we <= !r_store;
                r_state <= S_FIN;
              end
            end else begin
              r_k         <= w_k_next;
              r_mem_addr  <= r_addr + ADDR_W'(w_k_next);
              r_mem_wdata <= r_store ? f_word(w_k_next, r_s_base, r_s_len, r_s_cur,
                                              r_s_perms, r_s_attr, r_s_tag) : '0;
            end
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_fault <= 1'b0;
          r_code  <= 2'd0;
          r_cr_we <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ow_busy       = r_busy;
  assign ow_done       = r_done;
  assign ow_fault      = r_fault;
  assign ow_fault_code = r_code;
  assign ow_mem_req    = r_mem_req;
  assign ow_mem_we     = r_mem_we;
  assign ow_mem_addr   = r_mem_addr;
  assign ow_mem_wdata  = r_mem_wdata;
  assign ow_cr_we      = r_cr_we;
  assign ow_cr_base    = r_cr_we ? r_c_base  : '0;
  assign ow_cr_len     = r_cr_we ? r_c_len   : '0;
  assign ow_cr_cur     = r_cr_we ? r_c_cur   : '0;
  assign ow_cr_perms   = r_cr_we ? r_c_perms : '0;
  assign ow_cr_attr    = r_cr_we ? r_c_attr  : '0;
  assign ow_cr_tag     = r_cr_we & r_c_tag;

endmodule

// File: tb/tb_cap_xfer_seq.sv
// Scoreboard bench for cap_xfer_seq: a word-addressed memory model with
// random ack delay, a reference model of the fault rules and capability
// layout, and a monitor that pops expectations on every ow_done.
module tb_cap_xfer_seq;

  logic        r_clk = 1'b0, r_rst = 1'b0;
  logic        iw_start, iw_store, iw_auth_tag, iw_st_tag, iw_flush, iw_mem_ack;
  logic [47:0] iw_addr, iw_auth_base, iw_auth_len, iw_st_base, iw_st_len, iw_st_cur;
  logic [23:0] iw_auth_perms, iw_st_perms, iw_st_attr, iw_mem_rdata;
  logic        ow_busy, ow_done, ow_fault, ow_mem_req, ow_mem_we, ow_cr_we, ow_cr_tag;
  logic [1:0]  ow_fault_code;
  logic [47:0] ow_mem_addr, ow_cr_base, ow_cr_len, ow_cr_cur;
  logic [23:0] ow_mem_wdata, ow_cr_perms, ow_cr_attr;

  cap_xfer_seq dut (
    .r_clk(r_clk), .r_rst(r_rst), .iw_start(iw_start), .iw_store(iw_store),
    .iw_addr(iw_addr), .iw_auth_base(iw_auth_base), .iw_auth_len(iw_auth_len),
    .iw_auth_perms(iw_auth_perms), .iw_auth_tag(iw_auth_tag),
    .iw_st_base(iw_st_base), .iw_st_len(iw_st_len), .iw_st_cur(iw_st_cur),
    .iw_st_perms(iw_st_perms), .iw_st_attr(iw_st_attr), .iw_st_tag(iw_st_tag),
    .iw_flush(iw_flush), .ow_busy(ow_busy), .ow_done(ow_done), .ow_fault(ow_fault),
    .ow_fault_code(ow_fault_code), .ow_mem_req(ow_mem_req), .ow_mem_we(ow_mem_we),
    .ow_mem_addr(ow_mem_addr), .ow_mem_wdata(ow_mem_wdata), .iw_mem_ack(iw_mem_ack),
    .iw_mem_rdata(iw_mem_rdata), .ow_cr_we(ow_cr_we), .ow_cr_base(ow_cr_base),
    .ow_cr_len(ow_cr_len), .ow_cr_cur(ow_cr_cur), .ow_cr_perms(ow_cr_perms),
    .ow_cr_attr(ow_cr_attr), .ow_cr_tag(ow_cr_tag));

  always #5 r_clk = ~r_clk;

  int cyc = 0;
  always @(posedge r_clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        fault;
    logic [1:0]  code;
    logic        cr_we;
    logic [47:0] base, len, cur;
    logic [23:0] perms, attr;
    logic        tag;
    int          t0;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef logic [23:0] w12_t [12];

  logic [23:0] mem [logic [47:0]];

  function automatic logic [23:0] rd(input logic [47:0] a);
    return mem.exists(a) ? mem[a] : 24'h0;
  endfunction

  // Fault rules on unbounded integers: tag, then permission, then bounds.
  function automatic logic [1:0] model_code(input logic st, input logic [47:0] addr,
      input logic [47:0] base, len, input logic [23:0] perms, input logic tag);
    longint unsigned a, b, l;
    a = 64'(addr); b = 64'(base); l = 64'(len);
    if (!tag) return 2'd1;
    if (!(st ? perms[1] : perms[0])) return 2'd2;
    if (a < b || a + 12 > b + l) return 2'd3;
    return 2'd0;
  endfunction

  function automatic w12_t st_words(input logic [47:0] b, l, c,
      input logic [23:0] p, a, input logic t);
    w12_t w;
    w = '{b[23:0], b[47:24], l[23:0], l[47:24], c[23:0], c[47:24],
          p, 24'h0, a, 24'h0, {23'h0, t}, 24'h0};
    return w;
  endfunction

  // Monitor: every done pops one expectation.
  logic [47:0] last_base, last_len, last_cur;
  logic [23:0] last_perms, last_attr;
  logic        last_tag;
  always @(negedge r_clk) begin : mon
    exp_t e;
    if (ow_cr_we && !ow_done) chk("cr_we_without_done", 1, 0);
    if (ow_done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("fault", ow_fault, e.fault);
        chk("fault_code", ow_fault_code, e.code);
        chk("cr_we", ow_cr_we, e.cr_we);
        if (e.cr_we) begin
          chk("cr_base", ow_cr_base, e.base);
          chk("cr_len", ow_cr_len, e.len);
          chk("cr_cur", ow_cr_cur, e.cur);
          chk("cr_perms", ow_cr_perms, e.perms);
          chk("cr_attr", ow_cr_attr, e.attr);
          chk("cr_tag", ow_cr_tag, e.tag);
        end
        if (e.lat >= 0) chk("done_latency", 64'(cyc - e.t0), 64'(e.lat));
        last_base <= ow_cr_base; last_len <= ow_cr_len; last_cur <= ow_cr_cur;
        last_perms <= ow_cr_perms; last_attr <= ow_cr_attr; last_tag <= ow_cr_tag;
      end
    end
  end

  // Memory responder with random ack delay and hold-stability checks.
  int          max_wait = 0, wait_left = 0, ack_cnt = 0, req_cyc = 0, flush_cnt = 0;
  bit          hold_v = 0, flush_arm = 0;
  logic [47:0] hold_addr, flush_addr;
  logic [23:0] hold_wd;
  logic        hold_we;
  initial begin
    iw_mem_ack = 1'b0; iw_mem_rdata = '0; iw_flush = 1'b0;
    forever begin
      @(negedge r_clk);
      iw_flush = 1'b0;
      if (wait_left > max_wait) wait_left = max_wait;
      if (ow_mem_req) begin
        req_cyc++;
        if (hold_v) begin
          chk("hold_addr", ow_mem_addr, hold_addr);
          chk("hold_wdata", ow_mem_wdata, hold_wd);
          chk("hold_we", ow_mem_we, hold_we);
        end
        if (wait_left == 0) begin
          iw_mem_ack = 1'b1;
          iw_mem_rdata = rd(ow_mem_addr);
          if (flush_arm && ow_mem_addr == flush_addr) begin
            iw_flush = 1'b1; flush_arm = 0; flush_cnt++;
          end
        end else begin
          iw_mem_ack = 1'b0;
          iw_mem_rdata = 24'($urandom);
          wait_left--;
          hold_v = 1; hold_addr = ow_mem_addr; hold_wd = ow_mem_wdata; hold_we = ow_mem_we;
        end
      end else begin
        iw_mem_ack = 1'b0;
        hold_v = 0;
      end
      @(posedge r_clk);
      if (ow_mem_req && iw_mem_ack && r_rst) begin
        ack_cnt++;
        if (ow_mem_we) mem[ow_mem_addr] = ow_mem_wdata;
        hold_v = 0;
        wait_left = $urandom_range(max_wait, 0);
      end
    end
  end

  task automatic drive(input logic st, input logic [47:0] addr, ab, al,
      input logic [23:0] ap, input logic at, input logic [47:0] sb_, sl, sc,
      input logic [23:0] sp, sa, input logic s_t);
    iw_store = st; iw_addr = addr; iw_auth_base = ab; iw_auth_len = al;
    iw_auth_perms = ap; iw_auth_tag = at; iw_st_base = sb_; iw_st_len = sl;
    iw_st_cur = sc; iw_st_perms = sp; iw_st_attr = sa; iw_st_tag = s_t;
  endtask

  task automatic scramble();
    iw_store = 1'($urandom); iw_addr = {16'($urandom), 32'($urandom)};
    iw_auth_tag = 1'($urandom); iw_auth_perms = 24'($urandom);
    iw_st_base = {16'($urandom), 32'($urandom)}; iw_st_tag = 1'($urandom);
  endtask

  task automatic run(input logic st, input logic [47:0] addr, ab, al,
      input logic [23:0] ap, input logic at, input logic [47:0] sb_, sl, sc,
      input logic [23:0] sp, sa, input logic s_t, input bit lat_chk);
    exp_t e;
    int a0, r0, to;
    logic [23:0] t;
    @(negedge r_clk);
    drive(st, addr, ab, al, ap, at, sb_, sl, sc, sp, sa, s_t);
    e.code  = model_code(st, addr, ab, al, ap, at);
    e.fault = (e.code != 2'd0);
    e.cr_we = !st && !e.fault;
    e.base = {rd(addr + 1), rd(addr)};
    e.len  = {rd(addr + 3), rd(addr + 2)};
    e.cur  = {rd(addr + 5), rd(addr + 4)};
    e.perms = rd(addr + 6);
    e.attr  = rd(addr + 8);
    t = rd(addr + 10);
    e.tag = t[0];
    e.t0  = cyc;
    e.lat = lat_chk ? (e.fault ? 2 : 14) : -1;
    sb.push_back(e);
    a0 = ack_cnt; r0 = req_cyc;
    iw_start = 1'b1;
    @(posedge r_clk);
    #1;
    iw_start = 1'b0;
    scramble();
    chk("busy_rise", ow_busy, 1);
    to = 0;
    while (ow_busy && to < 200) begin @(negedge r_clk); to++; end
    if (to >= 200) chk("txn_timeout", 1, 0);
    chk("acks_consumed", 64'(ack_cnt - a0), e.fault ? 64'd0 : 64'd12);
    if (e.fault) chk("req_cycles_on_fault", 64'(req_cyc - r0), 0);
    chk("scoreboard_drained", 64'(sb.size()), 0);
  endtask

  task automatic basic_cld();
    w12_t w;
    w = '{24'd42, 24'd7, 24'd88, 24'd9, 24'd123, 24'd3, 24'hEE, 24'd0, 24'hAA, 24'd0, 24'd1, 24'd0};
    for (int i = 0; i < 12; i++) mem[48'd500 + 48'(i)] = w[i];
    run(0, 48'd500, 48'd0, 48'd1000, 24'h1, 1, '0, '0, '0, '0, '0, 0, 1);
    @(negedge r_clk);
    chk("basic_base", last_base, 48'h000007_00002A);
    chk("basic_len", last_len, 48'h000009_000058);
    chk("basic_cur", last_cur, 48'h000003_00007B);
    chk("basic_perms", last_perms, 24'hEE);
    chk("basic_attr", last_attr, 24'hAA);
    chk("basic_tag", last_tag, 1);
  endtask

  initial begin
    logic [47:0] b, l, c, a;
    logic [23:0] p, at_, pp;
    logic        tg;
    w12_t        w;
    int          a0, f0, to;
    iw_start = 1'b0;
    drive(0, '0, '0, '0, '0, 0, '0, '0, '0, '0, '0, 0);
    repeat (3) @(negedge r_clk);
    chk("reset_outputs", 64'(|{ow_busy, ow_done, ow_fault, ow_fault_code, ow_mem_req,
        ow_mem_we, ow_mem_addr, ow_mem_wdata, ow_cr_we, ow_cr_base, ow_cr_len,
        ow_cr_cur, ow_cr_perms, ow_cr_attr, ow_cr_tag}), 0);
    r_rst = 1'b1;

    basic_cld();

    // fault cases
    run(0, 48'd500, 48'd0, 48'd1000, 24'h3, 0, '0, '0, '0, '0, '0, 0, 1);
    run(0, 48'd500, 48'd0, 48'd1000, 24'h2, 1, '0, '0, '0, '0, '0, 0, 1);
    run(1, 48'd500, 48'd0, 48'd1000, 24'h1, 1, '0, '0, '0, '0, '0, 0, 1);
    run(0, 48'd988, 48'd0, 48'd1000, 24'h1, 1, '0, '0, '0, '0, '0, 0, 1);
    run(0, 48'd989, 48'd0, 48'd1000, 24'h1, 1, '0, '0, '0, '0, '0, 0, 1);
    run(0, 48'hFFFF_FFFF_FFF8, 48'd0, 48'd1000, 24'h1, 1, '0, '0, '0, '0, '0, 0, 1);
    run(0, 48'd9, 48'd10, 48'd1000, 24'h1, 1, '0, '0, '0, '0, '0, 0, 1);

    // CST then CLD round trip, then the same with wait states
    for (int pass = 0; pass < 2; pass++) begin
      max_wait = (pass == 0) ? 0 : 3;
      b = {16'($urandom), 32'($urandom)}; l = {16'($urandom), 32'($urandom)};
      c = {16'($urandom), 32'($urandom)}; p = 24'($urandom); at_ = 24'($urandom);
      tg = 1'($urandom);
      run(1, 48'd100, 48'd0, 48'd1000, 24'h3, 1, b, l, c, p, at_, tg, pass == 0);
      w = st_words(b, l, c, p, at_, tg);
      for (int i = 0; i < 12; i++) chk($sformatf("st_word%0d", i), rd(48'd100 + 48'(i)), w[i]);
      run(0, 48'd100, 48'd0, 48'd1000, 24'h1, 1, '0, '0, '0, '0, '0, 0, pass == 0);
      @(negedge r_clk);
      chk("rt_base", last_base, b); chk("rt_len", last_len, l); chk("rt_cur", last_cur, c);
      chk("rt_perms", last_perms, p); chk("rt_attr", last_attr, at_); chk("rt_tag", last_tag, tg);
    end

    // randomized mix with random waits
    for (int n = 0; n < 16; n++) begin
      max_wait = $urandom_range(3, 0);
      a = 48'($urandom_range(1100, 0));
      for (int i = 0; i < 12; i++) mem[a + 48'(i)] = 24'($urandom);
      pp = 24'($urandom_range(3, 0));
      run(1'($urandom), a, 48'($urandom_range(50, 0)), 48'($urandom_range(1100, 900)), pp,
          ($urandom_range(7, 0) != 0), {16'($urandom), 32'($urandom)},
          {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)},
          24'($urandom), 24'($urandom), 1'($urandom), max_wait == 0);
    end
    max_wait = 0;

    // flush on the word-5 ack
    @(negedge r_clk);
    drive(0, 48'd200, 48'd0, 48'd1000, 24'h1, 1, '0, '0, '0, '0, '0, 0);
    flush_addr = 48'd205; flush_arm = 1; f0 = flush_cnt; a0 = ack_cnt;
    iw_start = 1'b1;
    @(posedge r_clk); #1 iw_start = 1'b0;
    to = 0;
    while (flush_cnt == f0 && to < 50) begin @(posedge r_clk); to++; end
    #1;
    chk("flush_seen", 64'(flush_cnt - f0), 1);
    chk("flush_idle_next", ow_busy, 0);
    repeat (5) @(negedge r_clk);
    chk("flush_acks", 64'(ack_cnt - a0), 6);
    chk("flush_no_done", 64'(sb.size()), 0);

    // reset mid-transfer
    @(negedge r_clk);
    drive(0, 48'd300, 48'd0, 48'd1000, 24'h1, 1, '0, '0, '0, '0, '0, 0);
    a0 = ack_cnt; iw_start = 1'b1;
    @(posedge r_clk); #1 iw_start = 1'b0;
    to = 0;
    while (ack_cnt - a0 < 4 && to < 50) begin @(posedge r_clk); to++; end
    #2 r_rst = 1'b0;
    #1;
    chk("rst_outputs", 64'(|{ow_busy, ow_done, ow_fault, ow_fault_code, ow_mem_req,
        ow_mem_we, ow_mem_addr, ow_mem_wdata, ow_cr_we, ow_cr_base, ow_cr_len,
        ow_cr_cur, ow_cr_perms, ow_cr_attr, ow_cr_tag}), 0);
    repeat (2) @(negedge r_clk);
    r_rst = 1'b1;
    basic_cld();

    repeat (3) @(negedge r_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
